// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle for pipe_stage_reg. The slave modport is the register, the master modport the driver.
// Macro PIPE_STAGE_BUBBLE_CNT_EN adds cnt_clear_i / bubble_count_o.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic [OCC_W-1:0]  occupancy_o;
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    logic              cnt_clear_i;
    logic [15:0]       bubble_count_o;

    modport master (
        output stall_i, flush_i, valid_i, ctrl_i, data_i, cnt_clear_i,
        input  valid_o, ctrl_o, data_o, occupancy_o, bubble_count_o
    );
    modport slave (
        input  stall_i, flush_i, valid_i, ctrl_i, data_i, cnt_clear_i,
        output valid_o, ctrl_o, data_o, occupancy_o, bubble_count_o
    );
`else
    modport master (
        output stall_i, flush_i, valid_i, ctrl_i, data_i,
        input  valid_o, ctrl_o, data_o, occupancy_o
    );
    modport slave (
        input  stall_i, flush_i, valid_i, ctrl_i, data_i,
        output valid_o, ctrl_o, data_o, occupancy_o
    );
`endif
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots of {valid, ctrl, data} with stall and flush.
// Optional bubble counter enabled by macro PIPE_STAGE_BUBBLE_CNT_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_stage_reg_if.slave bus
);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = {OCC_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

    // Next slot contents: flush beats stall beats shift
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            ctrl_d[i] = ctrl_q[i];
            data_d[i] = data_q[i];
        end
        if (bus.flush_i) begin
            // Bubbles keep their data; only valid and control are killed
            valid_d = {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_d[i] = {CTRL_W{1'b0}};
            end
        end else if (bus.stall_i) begin
            valid_d = valid_q;
        end else begin
            valid_d[0] = bus.valid_i;
            ctrl_d[0]  = bus.valid_i ? bus.ctrl_i : {CTRL_W{1'b0}};
            data_d[0]  = bus.data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                ctrl_d[i]  = ctrl_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // Slot storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= {CTRL_W{1'b0}};
                data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= ctrl_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.valid_o     = valid_q[DEPTH-1];
    assign bus.ctrl_o      = ctrl_q[DEPTH-1];
    assign bus.data_o      = data_q[DEPTH-1];
    assign bus.occupancy_o = popcount(valid_q);

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    logic [15:0] bub_cnt_q;
    logic [15:0] bub_cnt_d;

    // Count unstalled edges that emit a bubble, saturating at all-ones
    always_comb begin
        bub_cnt_d = bub_cnt_q;
        if (bus.cnt_clear_i) begin
            bub_cnt_d = 16'h0000;
        end else if (!bus.stall_i && !valid_q[DEPTH-1] && (bub_cnt_q != 16'hFFFF)) begin
            bub_cnt_d = bub_cnt_q + 16'h0001;
        end else begin
            bub_cnt_d = bub_cnt_q;
        end
    end

    // Bubble counter storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_cnt_q <= 16'h0000;
        end else begin
            bub_cnt_q <= bub_cnt_d;
        end
    end

    assign bus.bubble_count_o = bub_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector bench for pipe_stage_reg (DEPTH=2); bubble counter vectors (DEPTH=1) under PIPE_STAGE_BUBBLE_CNT_EN.
module tb_pipe_stage_reg;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16), .DEPTH(2)) bus ();

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16), .DEPTH(1)) bus1 ();

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] c, input logic [31:0] d,
                         input logic st, input logic fl);
        bus.valid_i = v;
        bus.ctrl_i  = c;
        bus.data_i  = d;
        bus.stall_i = st;
        bus.flush_i = fl;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] c,
                           input logic [31:0] d, input logic [1:0] occ);
        chk({tag, ".valid"}, 64'(bus.valid_o), 64'(v));
        chk({tag, ".ctrl"},  64'(bus.ctrl_o),  64'(c));
        chk({tag, ".data"},  64'(bus.data_o),  64'(d));
        chk({tag, ".occ"},   64'(bus.occupancy_o), 64'(occ));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        drive(1'b1, 16'hBEEF, 32'hDEAD_0000, 1'b0, 1'b0);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
        bus.cnt_clear_i  = 1'b0;
        bus1.valid_i     = 1'b0;
        bus1.ctrl_i      = 16'h0000;
        bus1.data_i      = 32'h0;
        bus1.stall_i     = 1'b0;
        bus1.flush_i     = 1'b0;
        bus1.cnt_clear_i = 1'b0;
`endif
        #3;
        chk_out("rst0", 1'b0, 16'h0000, 32'h0, 2'd0);
        #9;
        chk_out("rst1", 1'b0, 16'h0000, 32'h0, 2'd0);
        rst_n = 1'b1;

        // 1: single entry, latency 2
        drive(1'b1, 16'hA5A5, 32'h0000_1234, 1'b0, 1'b0);
        tick();
        chk("t1.e1.valid", 64'(bus.valid_o), 64'd0);
        chk("t1.e1.occ",   64'(bus.occupancy_o), 64'd1);
        drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
        tick();
        chk_out("t1.e2", 1'b1, 16'hA5A5, 32'h0000_1234, 2'd1);
        tick();
        chk("t1.e3.valid", 64'(bus.valid_o), 64'd0);
        chk("t1.e3.ctrl",  64'(bus.ctrl_o),  64'd0);
        chk("t1.e3.occ",   64'(bus.occupancy_o), 64'd0);

        // 2: stream 1,2,3 with a stall once the pipe is full
        drive(1'b1, 16'h0001, 32'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 32'd2, 1'b0, 1'b0);
        tick();
        chk_out("t2.e2", 1'b1, 16'h0001, 32'd1, 2'd2);
        drive(1'b1, 16'h0003, 32'd3, 1'b1, 1'b0);
        tick();
        chk_out("t2.stall", 1'b1, 16'h0001, 32'd1, 2'd2);
        drive(1'b1, 16'h0003, 32'd3, 1'b0, 1'b0);
        tick();
        chk_out("t2.e4", 1'b1, 16'h0002, 32'd2, 2'd2);
        drive(1'b0, 16'h0000, 32'd0, 1'b0, 1'b0);
        tick();
        chk_out("t2.e5", 1'b1, 16'h0003, 32'd3, 2'd1);

        // 3: flush wins over stall
        drive(1'b1, 16'h1111, 32'd10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h2222, 32'd11, 1'b0, 1'b0);
        tick();
        chk_out("t3.full", 1'b1, 16'h1111, 32'd10, 2'd2);
        drive(1'b1, 16'h3333, 32'd99, 1'b1, 1'b1);
        tick();
        chk_out("t3.flush", 1'b0, 16'h0000, 32'd10, 2'd0);
        drive(1'b1, 16'h0F0F, 32'd20, 1'b0, 1'b0);
        tick();
        chk("t3.n1.valid", 64'(bus.valid_o), 64'd0);
        chk("t3.n1.occ",   64'(bus.occupancy_o), 64'd1);
        drive(1'b0, 16'h0000, 32'd0, 1'b0, 1'b0);
        tick();
        chk_out("t3.n2", 1'b1, 16'h0F0F, 32'd20, 2'd1);

        // 4: no ghost control when invalid, including X control/data
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, (i == 1) ? 16'hxxxx : 16'hFFFF, (i == 1) ? 32'hxxxx_xxxx : 32'd7, 1'b0, 1'b0);
            tick();
            chk("t4.valid", 64'(bus.valid_o), 64'd0);
            chk("t4.ctrl",  64'(bus.ctrl_o),  64'd0);
        end
        drive(1'b0, 16'hFFFF, 32'd7, 1'b0, 1'b0);
        tick();
        chk("t4.ctrlx", 64'(bus.ctrl_o), 64'd0);

        // 5: async reset in the middle of a stall
        drive(1'b1, 16'h4444, 32'd30, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h5555, 32'd31, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h6666, 32'd32, 1'b1, 1'b0);
        tick();
        chk_out("t5.stall", 1'b1, 16'h4444, 32'd30, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t5.async", 1'b0, 16'h0000, 32'd0, 2'd0);
        tick();
        chk_out("t5.held", 1'b0, 16'h0000, 32'd0, 2'd0);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 32'd0, 1'b0, 1'b0);
        tick();
        chk_out("t5.empty", 1'b0, 16'h0000, 32'd0, 2'd0);
        drive(1'b1, 16'h7777, 32'd40, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 32'd0, 1'b0, 1'b0);
        tick();
        chk_out("t5.restart", 1'b1, 16'h7777, 32'd40, 2'd1);

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
        // 6: bubble counter on the DEPTH=1 instance
        bus1.cnt_clear_i = 1'b1;
        tick();
        chk("t6.clr0", 64'(bus1.bubble_count_o), 64'd0);
        chk("t6.occ",  64'(bus1.occupancy_o), 64'(bus1.valid_o));
        bus1.cnt_clear_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6.idle5", 64'(bus1.bubble_count_o), 64'd5);
        bus1.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t6.stall", 64'(bus1.bubble_count_o), 64'd5);
        bus1.stall_i     = 1'b0;
        bus1.cnt_clear_i = 1'b1;
        tick();
        chk("t6.clr", 64'(bus1.bubble_count_o), 64'd0);
        bus1.cnt_clear_i = 1'b0;
        bus1.flush_i     = 1'b1;
        tick();
        chk("t6.flush", 64'(bus1.bubble_count_o), 64'd1);
        bus1.flush_i = 1'b0;
        for (int i = 0; i < 70000; i++) tick();
        chk("t6.sat", 64'(bus1.bubble_count_o), 64'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
